// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_responder_if
//   Bundles the core's data-memory port and the TX byte stream of the
//   data_mem_responder.
//   Memory port : R_en, W_en, ram_addr, Wr_mem_data (core -> responder)
//                 Rd_mem_data (responder -> core, combinational)
//   TX stream   : tx_data, tx_valid (responder -> sink), tx_ready (sink -> responder)
//   Modports    : master = core/sink side, slave = responder side.
// ---------------------------------------------------------------------------
interface data_mem_responder_if;
  logic        R_en;
  logic        W_en;
  logic [31:0] ram_addr;
  logic [31:0] Wr_mem_data;
  logic [31:0] Rd_mem_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output R_en, W_en, ram_addr, Wr_mem_data, tx_ready,
    input  Rd_mem_data, tx_data, tx_valid
  );

  modport slave (
    input  R_en, W_en, ram_addr, Wr_mem_data, tx_ready,
    output Rd_mem_data, tx_data, tx_valid
  );
endinterface

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//   Responder for the core's data-memory port. Holds a word-addressed data
//   RAM and an MMIO window (LED register, free-running timer, TX byte FIFO
//   drained by a downstream sink over valid/ready). Reads are combinational
//   so a single-cycle core never stalls.
//
//   Ports:
//     clk  in   clock, all state updates on the rising edge
//     rst  in   asynchronous, active-high reset (MMIO state only, RAM kept)
//     bus  slave modport of data_mem_responder_if
//            R_en/W_en/ram_addr/Wr_mem_data in, Rd_mem_data out
//            tx_data/tx_valid out, tx_ready in
//     led  out  16-bit LED register
//
//   MMIO map (ram_addr[31:16] == MMIO_BASE, offset = ram_addr[7:0]):
//     0x00 LED, 0x04 TIMER, 0x08 TX_DATA (write-only push),
//     0x0C TX_STAT {24'b0, count[3:0], ovf, 1'b0, empty, full}
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int          DEPTH_LOG2 = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] MMIO_BASE  = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus,
  output logic [15:0]          led
);

  localparam int RAM_WORDS = 1 << DEPTH_LOG2;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  localparam logic [7:0] OFF_LED     = 8'h00;
  localparam logic [7:0] OFF_TIMER   = 8'h04;
  localparam logic [7:0] OFF_TX_DATA = 8'h08;
  localparam logic [7:0] OFF_TX_STAT = 8'h0C;

  // Circular-buffer pointer advance, wrapping modulo FIFO_DEPTH.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // TX_STAT read image. Only the low four count bits are visible.
  function automatic logic [31:0] pack_tx_stat(input logic [CNT_W-1:0] cnt,
                                               input logic             ovf,
                                               input logic             empty,
                                               input logic             full);
    logic [3:0] cnt4;
    cnt4 = 4'(cnt);
    return {24'b0, cnt4, ovf, 1'b0, empty, full};
  endfunction

  // Storage (data only, never reset)
  logic [31:0] mem_q  [RAM_WORDS];
  logic [7:0]  fifo_q [FIFO_DEPTH];

  // Control state
  logic [15:0]      led_q,    led_d;
  logic [31:0]      timer_q,  timer_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             ovf_q,    ovf_d;

  // Decode
  logic                  mmio;
  logic [7:0]            off;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic                  ram_we;
  logic                  wr_led;
  logic                  wr_timer;
  logic                  wr_txd;
  logic                  wr_stat;
  logic                  unused_addr_bits;

  assign mmio     = (bus.ram_addr[31:16] == MMIO_BASE);
  assign off      = bus.ram_addr[7:0];
  assign ram_idx  = bus.ram_addr[DEPTH_LOG2+1:2];
  assign ram_we   = bus.W_en & ~mmio;
  assign wr_led   = bus.W_en & mmio & (off == OFF_LED);
  assign wr_timer = bus.W_en & mmio & (off == OFF_TIMER);
  assign wr_txd   = bus.W_en & mmio & (off == OFF_TX_DATA);
  assign wr_stat  = bus.W_en & mmio & (off == OFF_TX_STAT);

  // Byte-lane bits and RAM alias bits do not participate in decode.
  assign unused_addr_bits = ^bus.ram_addr;

  // FIFO status and handshake
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push_ok;
  logic push_rej;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign pop        = bus.tx_valid & bus.tx_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok    = wr_txd & (~fifo_full | pop);
  assign push_rej   = wr_txd & ~push_ok;

  assign bus.tx_valid = ~fifo_empty;
  assign bus.tx_data  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
  assign led          = led_q;

  // Read path: combinational, sees pre-edge state so read+write returns old data.
  always_comb begin
    bus.Rd_mem_data = 32'h0;
    if (bus.R_en) begin
      if (mmio) begin
        case (off)
          OFF_LED:     bus.Rd_mem_data = {16'h0, led_q};
          OFF_TIMER:   bus.Rd_mem_data = timer_q;
          OFF_TX_STAT: bus.Rd_mem_data = pack_tx_stat(count_q, ovf_q, fifo_empty, fifo_full);
          default:     bus.Rd_mem_data = 32'h0;
        endcase
      end else begin
        bus.Rd_mem_data = mem_q[ram_idx];
      end
    end
  end

  // Next-state for MMIO registers and FIFO control
  always_comb begin
    led_d    = led_q;
    timer_d  = timer_q + 32'd1;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (wr_led)   led_d   = bus.Wr_mem_data[15:0];
    if (wr_timer) timer_d = bus.Wr_mem_data;

    if (push_ok) wr_ptr_d = ptr_next(wr_ptr_q);
    if (pop)     rd_ptr_d = ptr_next(rd_ptr_q);

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Overflow is sticky; a rejected push outranks a clearing write.
    if (push_rej)     ovf_d = 1'b1;
    else if (wr_stat) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q    <= '0;
      timer_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      led_q    <= led_d;
      timer_q  <= timer_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we)  mem_q[ram_idx]   <= bus.Wr_mem_data;
    if (push_ok) fifo_q[wr_ptr_q] <= bus.Wr_mem_data[7:0];
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//   Drives the responder through directed scenarios and a randomized phase,
//   comparing every cycle against a behavioural model built from an array
//   (RAM), a byte queue (TX FIFO) and plain registers (LED, timer, overflow).
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int FD = 4;

  logic        clk;
  logic        rst;
  logic [15:0] led;

  data_mem_responder_if bus();

  data_mem_responder #(
    .DEPTH_LOG2 (8),
    .FIFO_DEPTH (FD),
    .MMIO_BASE  (16'hFFFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .led (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Behavioural model state
  logic [31:0] ram_m [256];
  logic [7:0]  q_m [$];
  logic [15:0] led_m;
  logic [31:0] timer_m;
  logic        ovf_m;

  logic [31:0] last_rd;
  logic [7:0]  last_txd;
  logic        last_vld;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic r, input logic [31:0] a);
    logic [3:0] c4;
    if (!r) return 32'h0;
    if (a[31:16] != 16'hFFFF) return ram_m[a[9:2]];
    c4 = 4'(q_m.size());
    case (a[7:0])
      8'h00:   return {16'h0, led_m};
      8'h04:   return timer_m;
      8'h0C:   return {24'h0, c4, ovf_m, 1'b0, (q_m.size() == 0), (q_m.size() == FD)};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic rdy);
    bit         is_mmio;
    logic [7:0] o;
    bit         pop;
    bit         push;
    int         n;
    is_mmio = (a[31:16] == 16'hFFFF);
    o       = a[7:0];
    n       = q_m.size();
    pop     = (n != 0) && rdy;
    push    = w && is_mmio && (o == 8'h08);
    timer_m = timer_m + 32'd1;
    if (w && !is_mmio) ram_m[a[9:2]] = d;
    if (w && is_mmio && o == 8'h00) led_m = d[15:0];
    if (w && is_mmio && o == 8'h04) timer_m = d;
    if (pop) void'(q_m.pop_front());
    if (push) begin
      if (n < FD || pop) q_m.push_back(d[7:0]);
      else ovf_m = 1'b1;
    end else if (w && is_mmio && o == 8'h0C) begin
      ovf_m = 1'b0;
    end
  endtask

  // One bus cycle: drive on the falling edge, check before the rising edge,
  // then advance the model with the same inputs.
  task automatic step(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic rdy);
    @(negedge clk);
    bus.R_en        = r;
    bus.W_en        = w;
    bus.ram_addr    = a;
    bus.Wr_mem_data = d;
    bus.tx_ready    = rdy;
    #1;
    last_rd  = bus.Rd_mem_data;
    last_txd = bus.tx_data;
    last_vld = bus.tx_valid;
    chk("rd", bus.Rd_mem_data, exp_rd(r, a));
    chk("tx_valid", {31'b0, bus.tx_valid}, {31'b0, (q_m.size() != 0)});
    chk("tx_data", {24'b0, bus.tx_data}, (q_m.size() != 0) ? {24'b0, q_m[0]} : 32'h0);
    chk("led", {16'b0, led}, {16'b0, led_m});
    @(posedge clk);
    model_edge(w, a, d, rdy);
  endtask

  // Asserts reset between clock edges, checks the immediate effect, holds it
  // across one rising edge and releases it just after.
  task automatic do_reset();
    #2;
    bus.R_en = 1'b0;
    bus.W_en = 1'b0;
    bus.tx_ready = 1'b0;
    rst = 1'b1;
    #1;
    q_m.delete();
    ovf_m   = 1'b0;
    led_m   = 16'h0;
    timer_m = 32'h0;
    chk("rst_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
    chk("rst_tx_data", {24'b0, bus.tx_data}, 32'h0);
    chk("rst_led", {16'b0, led}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  offs [5];
    total = 0;
    bad   = 0;
    led_m = 16'h0;
    timer_m = 32'h0;
    ovf_m = 1'b0;
    bus.R_en = 1'b0;
    bus.W_en = 1'b0;
    bus.ram_addr = 32'h0;
    bus.Wr_mem_data = 32'h0;
    bus.tx_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("init_led", {16'b0, led}, 32'h0);
    chk("init_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Give every RAM word a known value
    for (int i = 0; i < 256; i++) step(1'b0, 1'b1, i * 4, $urandom, 1'b0);

    // RAM basics
    step(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    step(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("t1_read", last_rd, 32'hDEADBEEF);
    step(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("t1_no_ren", last_rd, 32'h0);
    step(1'b1, 1'b1, 32'h10, 32'h1, 1'b0);
    chk("t1_rw_old", last_rd, 32'hDEADBEEF);
    step(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("t1_rw_new", last_rd, 32'h1);

    // LED and timer
    step(1'b0, 1'b1, 32'hFFFF0000, 32'h1234ABCD, 1'b0);
    step(1'b1, 1'b0, 32'hFFFF0000, 32'h0, 1'b0);
    chk("t2_led_rd", last_rd, 32'h0000ABCD);
    chk("t2_led_pin", {16'b0, led}, 32'h0000ABCD);
    step(1'b0, 1'b1, 32'hFFFF0004, 32'hFFFFFFFE, 1'b0);
    step(1'b1, 1'b0, 32'hFFFF0004, 32'h0, 1'b0);
    chk("t2_tmr0", last_rd, 32'hFFFFFFFE);
    step(1'b1, 1'b0, 32'hFFFF0004, 32'h0, 1'b0);
    chk("t2_tmr1", last_rd, 32'hFFFFFFFF);
    step(1'b1, 1'b0, 32'hFFFF0004, 32'h0, 1'b0);
    chk("t2_tmr2", last_rd, 32'h0);

    // Fill past capacity with sink stalled
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'hFFFF0008, 32'h11 + i, 1'b0);
    step(1'b1, 1'b0, 32'hFFFF000C, 32'h0, 1'b0);
    chk("t3_stat_full", last_rd, 32'h49);
    chk("t3_head", {24'b0, last_txd}, 32'h11);
    step(1'b0, 1'b1, 32'hFFFF000C, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'hFFFF000C, 32'h0, 1'b0);
    chk("t3_stat_clr", last_rd, 32'h41);

    // Drain
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      chk("t4_drain", {24'b0, last_txd}, 32'h11 + i);
    end
    step(1'b1, 1'b0, 32'hFFFF000C, 32'h0, 1'b1);
    chk("t4_empty_vld", {31'b0, last_vld}, 32'h0);
    chk("t4_stat", last_rd, 32'h02);

    // Push into a full FIFO while the head leaves
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'hFFFF0008, 32'hA1 + i, 1'b0);
    step(1'b0, 1'b1, 32'hFFFF0008, 32'h99, 1'b1);
    step(1'b1, 1'b0, 32'hFFFF000C, 32'h0, 1'b0);
    chk("t5_stat", last_rd, 32'h41);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      chk("t5_drain", {24'b0, last_txd}, 32'hA2 + i);
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("t5_last", {24'b0, last_txd}, 32'h99);

    // Asynchronous reset with two entries queued
    step(1'b0, 1'b1, 32'hFFFF0008, 32'h55, 1'b0);
    step(1'b0, 1'b1, 32'hFFFF0008, 32'h66, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("t6_ram_kept", last_rd, 32'h1);

    // Randomized traffic
    offs[0] = 8'h00;
    offs[1] = 8'h04;
    offs[2] = 8'h08;
    offs[3] = 8'h0C;
    offs[4] = 8'h10;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) < 4) begin
        a = {16'($urandom_range(0, 16'hFFFE)), 16'($urandom)};
      end else begin
        a = {16'hFFFF, 8'($urandom), offs[$urandom_range(0, 4)]};
        if ($urandom_range(0, 15) == 0) a[7:0] = 8'($urandom);
      end
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a, $urandom,
           1'($urandom_range(0, 1)));
      if ($urandom_range(0, 255) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
